// File: rtl/stall_mgmt_mc.sv
// -----------------------------------------------------------------------------
// stall_mgmt_mc
//   Per-channel stall manager. Each channel runs a small IDLE/STALL/HOLD FSM
//   driven by its request (buffer full and not granted). A stall persists for
//   HOLD_CYCLES cycles after the request goes away, so the pipeline does not
//   chatter on short gaps. A per-channel wait counter flags starvation once a
//   channel has spent STARVE_LIMIT cycles in STALL within one stall episode.
//   A global saturating counter records how many cycles any channel stalled.
//
// Ports
//   clk            : single clock, all state on the rising edge
//   reset_n        : asynchronous active-low reset
//   arbiter_grant  : per-channel grant from the arbiter
//   to_stall_mgmt  : per-channel buffer-full indication
//   global_mode    : 1 = any channel stall stalls every channel
//   clear_count    : synchronous clear of stall_count (beats increment)
//   stall_output   : per-channel stall to the pipeline
//   global_stall   : OR of all per-channel stall states
//   starve         : per-channel starvation flag
//   stall_count    : saturating count of cycles with global_stall high
// -----------------------------------------------------------------------------
module stall_mgmt_mc #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned HOLD_CYCLES  = 2,
  parameter int unsigned STARVE_LIMIT = 15,
  parameter int unsigned CNT_W        = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] arbiter_grant,
  input  logic [NUM_CH-1:0] to_stall_mgmt,
  input  logic              global_mode,
  input  logic              clear_count,
  output logic [NUM_CH-1:0] stall_output,
  output logic              global_stall,
  output logic [NUM_CH-1:0] starve,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STALL = 2'd1,
    ST_HOLD  = 2'd2
  } ch_state_e;

  // With HOLD_CYCLES = 0 the HOLD state is never entered.
  localparam bit              HOLD_EN    = (HOLD_CYCLES != 0);
  localparam logic [3:0]      HOLD_LOAD  = (HOLD_CYCLES == 0) ? 4'd0 : 4'(HOLD_CYCLES - 1);
  localparam logic [7:0]      WAIT_MAX   = 8'hFF;
  localparam logic [7:0]      STARVE_LIM = 8'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [NUM_CH-1:0] ch_stall_s;
  logic [NUM_CH-1:0] ch_starve_s;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    ch_state_e  state_q, state_d;
    logic [3:0] hold_q, hold_d;
    logic [7:0] wait_q, wait_d;
    logic       stall_q, stall_d;
    logic       starve_q, starve_d;
    logic       req_s;

    // A grant in the same cycle as full cancels the request.
    assign req_s = to_stall_mgmt[gi] & ~arbiter_grant[gi];

    // Next-state and hold-counter logic of the channel FSM.
    always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      case (state_q)
        ST_IDLE: begin
          hold_d = 4'd0;
          if (req_s) begin
            state_d = ST_STALL;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_STALL: begin
          if (req_s) begin
            state_d = ST_STALL;
          end else if (HOLD_EN) begin
            state_d = ST_HOLD;
            hold_d  = HOLD_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (req_s) begin
            // Request came back: resume stalling, remaining hold time is dropped.
            state_d = ST_STALL;
            hold_d  = 4'd0;
          end else if (hold_q == 4'd0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
            hold_d  = hold_q - 4'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          hold_d  = 4'd0;
        end
      endcase
    end

    // Wait counter counts STALL cycles only; it is frozen in HOLD so a
    // request returning during HOLD resumes from the held value.
    always_comb begin
      if (state_d == ST_IDLE) begin
        wait_d = 8'd0;
      end else if ((state_q == ST_STALL) && (wait_q != WAIT_MAX)) begin
        wait_d = wait_q + 8'd1;
      end else begin
        wait_d = wait_q;
      end
    end

    // Registered stall and sticky starvation flag, both cleared on entry to IDLE.
    always_comb begin
      stall_d = (state_d != ST_IDLE);
      if (state_d == ST_IDLE) begin
        starve_d = 1'b0;
      end else if (wait_d >= STARVE_LIM) begin
        starve_d = 1'b1;
      end else begin
        starve_d = starve_q;
      end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q  <= ST_IDLE;
        hold_q   <= 4'd0;
        wait_q   <= 8'd0;
        stall_q  <= 1'b0;
        starve_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        hold_q   <= hold_d;
        wait_q   <= wait_d;
        stall_q  <= stall_d;
        starve_q <= starve_d;
      end
    end

    assign ch_stall_s[gi]  = stall_q;
    assign ch_starve_s[gi] = starve_q;
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Global stall-cycle counter: clear wins, otherwise saturating increment.
  always_comb begin
    if (clear_count) begin
      cnt_d = '0;
    end else if (global_stall && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Global counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Output select; global_mode acts in the same cycle it changes.
  always_comb begin
    global_stall = |ch_stall_s;
    if (global_mode) begin
      stall_output = {NUM_CH{global_stall}};
    end else begin
      stall_output = ch_stall_s;
    end
  end

  assign starve      = ch_starve_s;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_stall_mgmt_mc.sv
// -----------------------------------------------------------------------------
// tb_stall_mgmt_mc
//   Self-checking bench for stall_mgmt_mc (NUM_CH=4, HOLD_CYCLES=2,
//   STARVE_LIMIT=15, CNT_W=4). The reference model describes a channel by the
//   cycle of its last request: a channel stalls in the HOLD_CYCLES+1 cycles
//   following any request. Directed scenarios use constant expectations.
// -----------------------------------------------------------------------------
module tb_stall_mgmt_mc;

  localparam int NCH  = 4;
  localparam int HOLD = 2;
  localparam int SLIM = 15;
  localparam int CMAX = 15;

  logic       clk;
  logic       reset_n;
  logic [3:0] arbiter_grant;
  logic [3:0] to_stall_mgmt;
  logic       global_mode;
  logic       clear_count;
  logic [3:0] stall_output;
  logic       global_stall;
  logic [3:0] starve;
  logic [3:0] stall_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state
  int cyc;
  int last_req [NCH];
  bit prev_req [NCH];
  int wait_m   [NCH];
  bit starve_m [NCH];
  int cnt_m;

  logic [3:0] rf;
  logic [3:0] rg;

  stall_mgmt_mc #(
    .NUM_CH      (4),
    .HOLD_CYCLES (2),
    .STARVE_LIMIT(15),
    .CNT_W       (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .arbiter_grant(arbiter_grant),
    .to_stall_mgmt(to_stall_mgmt),
    .global_mode  (global_mode),
    .clear_count  (clear_count),
    .stall_output (stall_output),
    .global_stall (global_stall),
    .starve       (starve),
    .stall_count  (stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit m_stalled(input int i);
    int d;
    d = cyc - last_req[i];
    return (d >= 1) && (d <= HOLD + 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      last_req[i] = -1000;
      prev_req[i] = 1'b0;
      wait_m[i]   = 0;
      starve_m[i] = 1'b0;
    end
    cnt_m = 0;
  endtask

  task automatic model_update(input logic [3:0] g, input logic [3:0] f, input logic cc);
    bit any_now;
    bit in_stall_state [NCH];
    any_now = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      any_now = any_now | m_stalled(i);
      // Channel is actively stalling (not just holding) when it requested last cycle.
      in_stall_state[i] = prev_req[i];
      if (f[i] && !g[i]) last_req[i] = cyc;
      prev_req[i] = f[i] && !g[i];
    end
    cyc++;
    for (int i = 0; i < NCH; i++) begin
      if (!m_stalled(i)) begin
        wait_m[i]   = 0;
        starve_m[i] = 1'b0;
      end else begin
        if (in_stall_state[i] && wait_m[i] < 255) wait_m[i]++;
        if (wait_m[i] >= SLIM) starve_m[i] = 1'b1;
      end
    end
    if (cc) cnt_m = 0;
    else if (any_now && cnt_m < CMAX) cnt_m++;
  endtask

  // Drive inputs for the current cycle and compare all outputs with the model.
  task automatic apply(input logic [3:0] g, input logic [3:0] f, input logic gm, input logic cc);
    logic [3:0] ech;
    logic [3:0] est;
    logic       eany;
    arbiter_grant = g;
    to_stall_mgmt = f;
    global_mode   = gm;
    clear_count   = cc;
    #1;
    for (int i = 0; i < NCH; i++) begin
      ech[i] = m_stalled(i);
      est[i] = starve_m[i];
    end
    eany = |ech;
    chk("stall_output", 32'(stall_output), 32'(gm ? {4{eany}} : ech));
    chk("global_stall", 32'(global_stall), 32'(eany));
    chk("starve",       32'(starve),       32'(est));
    chk("stall_count",  32'(stall_count),  32'(cnt_m));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_update(arbiter_grant, to_stall_mgmt, clear_count);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      apply(4'd0, 4'd0, 1'b0, 1'b0);
      tick();
    end
  endtask

  initial begin
    cyc     = 0;
    reset_n = 1'b0;
    arbiter_grant = 4'd0;
    to_stall_mgmt = 4'd0;
    global_mode   = 1'b0;
    clear_count   = 1'b0;
    model_reset();

    // Reset state, with a request present to show reset dominates.
    apply(4'd0, 4'b1111, 1'b0, 1'b0);
    tick();
    apply(4'd0, 4'b1111, 1'b1, 1'b0);
    tick();
    to_stall_mgmt = 4'd0;
    reset_n = 1'b1;
    idle(3);

    // Channel 0: stall from cycle 1, grant at cycle 5, drop at cycle 8.
    for (int t = 0; t < 10; t++) begin
      apply((t >= 5) ? 4'b0001 : 4'b0000, 4'b0001, 1'b0, 1'b0);
      chk("ch0_hold_seq", 32'(stall_output[0]), 32'((t >= 1) && (t <= 7)));
      tick();
    end
    idle(5);

    // Global mode broadcast and same-cycle mode switch.
    apply(4'd0, 4'b0100, 1'b1, 1'b0);
    chk("gm_before", 32'(stall_output), 32'(4'b0000));
    tick();
    apply(4'd0, 4'b0100, 1'b1, 1'b0);
    chk("gm_on", 32'(stall_output), 32'(4'b1111));
    apply(4'd0, 4'b0100, 1'b0, 1'b0);
    chk("gm_off", 32'(stall_output), 32'(4'b0100));
    tick();
    idle(5);

    // Channel 1 continuous: starvation at the 16th stall cycle, count saturation.
    for (int t = 0; t < 24; t++) begin
      apply(4'd0, 4'b0010, 1'b0, 1'b0);
      chk("starve1_rise", 32'(starve[1]), 32'(t >= 16));
      chk("stall1_on",    32'(stall_output[1]), 32'(t >= 1));
      tick();
    end
    apply(4'd0, 4'b0010, 1'b0, 1'b1);
    chk("cnt_sat", 32'(stall_count), 32'(4'd15));
    tick();
    apply(4'd0, 4'b0010, 1'b0, 1'b0);
    chk("cnt_clear", 32'(stall_count), 32'(4'd0));
    chk("cnt_clear_gs", 32'(global_stall), 32'(1'b1));
    tick();
    for (int t = 26; t < 31; t++) begin
      apply(4'd0, 4'b0000, 1'b0, 1'b0);
      chk("starve1_fall", 32'(starve[1]), 32'(t <= 28));
      chk("stall1_fall",  32'(stall_output[1]), 32'(t <= 28));
      tick();
    end
    idle(4);

    // Channel 3: request returns in the first HOLD cycle; wait count resumes.
    for (int t = 0; t < 19; t++) begin
      apply(4'd0, ((t <= 9) || (t >= 11)) ? 4'b1000 : 4'b0000, 1'b0, 1'b0);
      chk("rehold_stall",  32'(stall_output[3]), 32'(t >= 1));
      chk("rehold_starve", 32'(starve[3]), 32'(t >= 17));
      tick();
    end
    idle(6);

    // Randomized traffic against the model.
    rf = 4'd0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 7) == 0) rf[i] = ~rf[i];
      end
      rg = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      apply(rg, rf, ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
      tick();
    end
    idle(6);

    // Asynchronous reset in the middle of HOLD.
    for (int t = 0; t < 3; t++) begin
      apply(4'd0, 4'b0001, 1'b0, 1'b0);
      tick();
    end
    apply(4'd0, 4'b0000, 1'b0, 1'b0);
    tick();
    apply(4'd0, 4'b0000, 1'b0, 1'b0);
    chk("pre_reset_hold", 32'(stall_output[0]), 32'(1'b1));
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_so",  32'(stall_output), 32'(4'd0));
    chk("async_rst_gs",  32'(global_stall), 32'(1'b0));
    chk("async_rst_st",  32'(starve),       32'(4'd0));
    chk("async_rst_cnt", 32'(stall_count),  32'(4'd0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("rst_held_so", 32'(stall_output), 32'(4'd0));
    reset_n = 1'b1;
    // First cycle after reset behaves as from IDLE.
    apply(4'd0, 4'b0001, 1'b0, 1'b0);
    chk("post_rst_idle", 32'(stall_output[0]), 32'(1'b0));
    tick();
    apply(4'd0, 4'b0001, 1'b0, 1'b0);
    chk("post_rst_stall", 32'(stall_output[0]), 32'(1'b1));
    tick();
    idle(5);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
